// File: rtl/adder_pkg.sv
// Shared widths and load-FSM encoding for the adder front end.
package adder_pkg;
  localparam int BYTE_W_DEF = 8;
  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } load_state_t;
endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one bouncy button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Final differing sample: accept the new level; only a press raises an event.
        stable <= sync_p1;
        cnt    <= '0;
        rise   <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/operand_loader.sv
// Loads two WORD_W operands one switch byte per debounced "set" press; "clear" restarts entry.
module operand_loader
  import adder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BYTE_W          = BYTE_W_DEF,
  parameter int WORD_W          = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] inp,
  input  logic              set_btn,
  input  logic              clear_btn,
  output logic [WORD_W-1:0] numA,
  output logic [WORD_W-1:0] numB,
  output logic              operands_valid,
  output logic [2:0]        byte_idx,
  output logic              load_pulse
);
  logic              set_rise;
  logic              clr_rise;
  logic [BYTE_W-1:0] inp_p0;
  logic [BYTE_W-1:0] inp_p1;
  load_state_t       state;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (set_btn),
    .rise  (set_rise)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (clear_btn),
    .rise  (clr_rise)
  );

  // Switch byte synchroniser stage p0 -> p1
  always_ff @(posedge clk) begin
    inp_p0 <= inp;
    inp_p1 <= inp_p0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      numA           <= '0;
      numB           <= '0;
      byte_idx       <= 3'd0;
      operands_valid <= 1'b0;
      load_pulse     <= 1'b0;
      state          <= LOAD_A;
    end else begin
      // A set event that coincides with clear, or arrives while full, is dropped here.
      load_pulse <= set_rise && !clr_rise && (state != FULL);
      if (clr_rise) begin
        numA           <= '0;
        numB           <= '0;
        byte_idx       <= 3'd0;
        operands_valid <= 1'b0;
        state          <= LOAD_A;
      end else if (load_pulse) begin
        if (byte_idx[2])
          numB[int'(byte_idx[1:0])*BYTE_W +: BYTE_W] <= inp_p1;
        else
          numA[int'(byte_idx[1:0])*BYTE_W +: BYTE_W] <= inp_p1;
        byte_idx <= byte_idx + 3'd1;
        if (byte_idx == 3'd3) state <= LOAD_B;
        if (byte_idx == 3'd7) begin
          state          <= FULL;
          operands_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_operand_loader.sv
// Directed/randomised bench for operand_loader with a byte-list reference model.
module tb_operand_loader;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  inp;
  logic        set_btn;
  logic        clear_btn;
  logic [31:0] numA;
  logic [31:0] numB;
  logic        operands_valid;
  logic [2:0]  byte_idx;
  logic        load_pulse;

  int checks   = 0;
  int failures = 0;

  // Reference model: list of bytes entered since the last clear/reset.
  logic [7:0] mbytes [8];
  int         mcount;

  int pulses;
  int first_pulse;

  operand_loader #(.DEBOUNCE_CYCLES(D), .BYTE_W(8), .WORD_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .inp            (inp),
    .set_btn        (set_btn),
    .clear_btn      (clear_btn),
    .numA           (numA),
    .numB           (numB),
    .operands_valid (operands_valid),
    .byte_idx       (byte_idx),
    .load_pulse     (load_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mbytes[i] = 8'h00;
    mcount = 0;
  endtask

  task automatic model_press(input logic [7:0] v);
    if (mcount < 8) begin
      mbytes[mcount] = v;
      mcount++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ea;
    logic [31:0] eb;
    ea = {mbytes[3], mbytes[2], mbytes[1], mbytes[0]};
    eb = {mbytes[7], mbytes[6], mbytes[5], mbytes[4]};
    chk({tag, "_numA"}, numA, ea);
    chk({tag, "_numB"}, numB, eb);
    chk({tag, "_idx"}, {29'd0, byte_idx}, 32'(mcount % 8));
    chk({tag, "_valid"}, {31'd0, operands_valid}, {31'd0, mcount == 8});
  endtask

  // Hold the given buttons for 'hold' cycles, then release for long enough to settle low.
  task automatic press(input logic [7:0] v, input bit s, input bit c, input int hold);
    inp         = v;
    set_btn     = s;
    clear_btn   = c;
    pulses      = 0;
    first_pulse = -1;
    for (int i = 1; i <= hold + 2*D + 4; i++) begin
      if (i == hold + 1) begin
        set_btn   = 1'b0;
        clear_btn = 1'b0;
      end
      tick();
      if (load_pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
  endtask

  initial begin
    logic [7:0] v;
    int         h;
    rst_n = 1'b0; inp = 8'h00; set_btn = 1'b0; clear_btn = 1'b0;
    model_clear();
    #2;
    chk("rst_numA", numA, 32'h0);
    chk("rst_lp", {31'd0, load_pulse}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Idle
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (load_pulse) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    check_model("idle");

    // First load: latency and single pulse for a long hold
    press(8'h11, 1'b1, 1'b0, 10);
    model_press(8'h11);
    chk("lat_first", 32'(first_pulse), 32'(D + 3));
    chk("lat_count", 32'(pulses), 32'd1);
    check_model("first");

    press(8'h00, 1'b0, 1'b1, 8);
    model_clear();
    chk("clr_pulses", 32'(pulses), 32'd0);
    check_model("clr1");

    // Eight fixed presses fill both operands
    for (int k = 1; k <= 8; k++) begin
      v = 8'(k * 8'h11);
      press(v, 1'b1, 1'b0, 6 + k);
      model_press(v);
      chk("fill_pulse", 32'(pulses), 32'd1);
    end
    chk("fill_numA", numA, 32'h44332211);
    chk("fill_numB", numB, 32'h88776655);
    check_model("fill");

    // Ninth press is ignored while full
    press(8'hEE, 1'b1, 1'b0, 9);
    chk("full_pulse", 32'(pulses), 32'd0);
    check_model("full");

    press(8'h00, 1'b0, 1'b1, 8);
    model_clear();
    check_model("clr2");

    // Random loads, then bounce that never stays stable long enough
    for (int k = 0; k < 2; k++) begin
      v = 8'($urandom);
      h = 7 + int'($urandom_range(0, 12));
      press(v, 1'b1, 1'b0, h);
      model_press(v);
      chk("rnd_pulse", 32'(pulses), 32'd1);
    end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      set_btn = ~set_btn;
      tick();
      if (load_pulse) pulses++;
    end
    set_btn = 1'b0;
    for (int i = 0; i < 2*D + 4; i++) begin
      tick();
      if (load_pulse) pulses++;
    end
    chk("bounce_pulses", 32'(pulses), 32'd0);
    check_model("bounce");

    // Up to five loads, then set and clear together
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom);
      press(v, 1'b1, 1'b0, 8 + int'($urandom_range(0, 5)));
      model_press(v);
    end
    check_model("five");
    press(8'h5A, 1'b1, 1'b1, 10);
    model_clear();
    chk("simul_pulse", 32'(pulses), 32'd0);
    check_model("simul");

    // Reset in the middle of a held press, set still held after release
    for (int k = 0; k < 3; k++) begin
      v = 8'($urandom);
      press(v, 1'b1, 1'b0, 8);
      model_press(v);
    end
    check_model("prerst");
    v = 8'($urandom);
    inp = v;
    set_btn = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_model("async_rst");
    tick();
    rst_n = 1'b1;
    pulses = 0;
    first_pulse = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (load_pulse) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    set_btn = 1'b0;
    model_press(v);
    chk("rst_lat", 32'(first_pulse), 32'(D + 3));
    chk("rst_count", 32'(pulses), 32'd1);
    check_model("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
